// File: rtl/rx_oversample_voter_pkg.sv
// Shared widths, window helpers and decision type for the RX oversampling voter family.
package rx_sampler_pkg;

  localparam int unsigned MAX_PRESCALE_DEF = 32;
  localparam int unsigned NUM_SAMPLES_DEF  = 3;
  localparam int unsigned CNT_W            = $clog2(MAX_PRESCALE_DEF);
  localparam int unsigned PS_W             = CNT_W + 1;
  localparam int unsigned VOTE_W           = $clog2(NUM_SAMPLES_DEF + 1);

  typedef struct packed {
    logic sampled;
    logic noise;
  } decision_t;

  localparam decision_t DECISION_RST = '{sampled: 1'b1, noise: 1'b0};

  function automatic int unsigned win_mid(input int unsigned prescale);
    return prescale >> 1;
  endfunction

  // n is odd, so n-1 == 2H and the window ends exactly on mid-bit.
  function automatic int unsigned win_start(input int unsigned prescale, input int unsigned n);
    return win_mid(prescale) - (n - 1);
  endfunction

endpackage

// File: rtl/rx_oversample_voter_if.sv
// Control and decision bundle between the RX FSM (master) and the bit voter (slave).
interface rx_oversample_voter_if #(
  parameter int MAX_PRESCALE = 32
);
  localparam int CW = $clog2(MAX_PRESCALE);

  logic          i_enable;
  logic          i_resync;
  logic [CW:0]   i_prescale;
  logic          i_rx;
  logic          o_bit_valid;
  logic          o_sampled_bit;
  logic          o_noise;
  logic [CW-1:0] o_edge_count;
  logic          o_cfg_err;

  modport master (
    output i_enable, i_resync, i_prescale, i_rx,
    input  o_bit_valid, o_sampled_bit, o_noise, o_edge_count, o_cfg_err
  );

  modport slave (
    input  i_enable, i_resync, i_prescale, i_rx,
    output o_bit_valid, o_sampled_bit, o_noise, o_edge_count, o_cfg_err
  );

endinterface

// File: rtl/rx_oversample_voter_sync.sv
// Multi-flop synchroniser for an asynchronous serial line; resets to the idle (high) level.
module rx_sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rx_oversample_voter.sv
// Oversampling bit timer with a mid-bit majority vote; one strobed decision per bit period.
module rx_oversample_voter
  import rx_sampler_pkg::*;
#(
  parameter int MAX_PRESCALE = 32,
  parameter int NUM_SAMPLES  = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  rx_oversample_voter_if.slave  bus
);

  localparam int CW = $clog2(MAX_PRESCALE);
  localparam int PW = CW + 1;
  localparam int VW = $clog2(NUM_SAMPLES + 1);
  localparam int H  = (NUM_SAMPLES - 1) / 2;

  logic          rx_s;
  logic [PW-1:0] prescale_q, prescale_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] ones_q, ones_d, seen_q, seen_d;
  logic          valid_q, valid_d;
  decision_t     dec_q, dec_d;
  logic          cfg_err_q;

  logic          legal, run, in_win, at_mid, wrap;
  logic [PW-1:0] mid, win_lo, cnt_ext;
  logic [VW-1:0] ones_tot, seen_tot;

  rx_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (bus.i_rx),
    .o_q     (rx_s)
  );

  assign cnt_ext  = {1'b0, cnt_q};
  assign legal    = (prescale_q >= PW'(2 * NUM_SAMPLES)) && (prescale_q <= PW'(MAX_PRESCALE));
  assign run      = bus.i_enable && legal && !bus.i_resync;
  assign mid      = PW'(win_mid(32'(prescale_q)));
  assign win_lo   = PW'(win_start(32'(prescale_q), NUM_SAMPLES));
  assign in_win   = (cnt_ext >= win_lo) && (cnt_ext <= mid);
  assign at_mid   = (cnt_ext == mid);
  assign wrap     = (cnt_ext >= prescale_q - PW'(1));
  assign ones_tot = ones_q + VW'(rx_s);
  assign seen_tot = seen_q + VW'(1);

  always_comb begin
    prescale_d = prescale_q;
    cnt_d      = cnt_q;
    ones_d     = ones_q;
    seen_d     = seen_q;
    valid_d    = 1'b0;
    dec_d      = dec_q;

    // Ratio only changes while idle or at a start-edge realignment.
    if (!bus.i_enable || bus.i_resync) prescale_d = bus.i_prescale;

    if (!run) begin
      cnt_d  = '0;
      ones_d = '0;
      seen_d = '0;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
      if (in_win) begin
        if (at_mid) begin
          ones_d = '0;
          seen_d = '0;
          // Only a complete window may produce a decision.
          if (seen_tot == VW'(NUM_SAMPLES)) begin
            valid_d       = 1'b1;
            dec_d.sampled = (ones_tot > VW'(H));
            dec_d.noise   = (ones_tot != '0) && (ones_tot != VW'(NUM_SAMPLES));
          end
        end else begin
          ones_d = ones_tot;
          seen_d = seen_tot;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prescale_q <= PW'(MAX_PRESCALE);
      cnt_q      <= '0;
      ones_q     <= '0;
      seen_q     <= '0;
      valid_q    <= 1'b0;
      dec_q      <= DECISION_RST;
      cfg_err_q  <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      ones_q     <= ones_d;
      seen_q     <= seen_d;
      valid_q    <= valid_d;
      dec_q      <= dec_d;
      cfg_err_q  <= !legal;
    end
  end

  assign bus.o_bit_valid   = valid_q;
  assign bus.o_sampled_bit = dec_q.sampled;
  assign bus.o_noise       = dec_q.noise;
  assign bus.o_edge_count  = cnt_q;
  assign bus.o_cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_rx_oversample_voter.sv
// Directed bench for rx_oversample_voter: N=3 and N=5 instances sharing one clock.
module tb_rx_oversample_voter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  rx_oversample_voter_if #(.MAX_PRESCALE(32)) bus  ();
  rx_oversample_voter_if #(.MAX_PRESCALE(32)) bus5 ();

  rx_oversample_voter #(.MAX_PRESCALE(32), .NUM_SAMPLES(3), .SYNC_STAGES(2)) dut (
    .i_clk (clk), .i_rst_n (rst_n), .bus (bus)
  );

  rx_oversample_voter #(.MAX_PRESCALE(32), .NUM_SAMPLES(5), .SYNC_STAGES(2)) dut5 (
    .i_clk (clk), .i_rst_n (rst_n), .bus (bus5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_enable = 1'b0;  bus.i_resync = 1'b0;  bus.i_prescale = 6'd8;  bus.i_rx = 1'b1;
    bus5.i_enable = 1'b0; bus5.i_resync = 1'b0; bus5.i_prescale = 6'd32; bus5.i_rx = 1'b1;
    #12;
    n_total++; if (bus.o_bit_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.o_bit_valid); else n_pass++;
    n_total++; if (bus.o_sampled_bit !== 1'b1) $display("FAIL rst_sampled got %b exp 1", bus.o_sampled_bit); else n_pass++;
    n_total++; if (bus.o_noise !== 1'b0) $display("FAIL rst_noise got %b exp 0", bus.o_noise); else n_pass++;
    n_total++; if (bus.o_edge_count !== 5'd0) $display("FAIL rst_count got %0d exp 0", bus.o_edge_count); else n_pass++;
    n_total++; if (bus.o_cfg_err !== 1'b0) $display("FAIL rst_cfg_err got %b exp 0", bus.o_cfg_err); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  // Prescale 8, steady 0: strobe 5 clocks after resync, then every 8.
  task automatic test_basic();
    logic exp_v;
    bus.i_enable = 1'b0; bus.i_prescale = 6'd8; bus.i_rx = 1'b0;
    repeat (3) tick();
    n_total++; if (bus.o_cfg_err !== 1'b0) $display("FAIL basic_cfg_err got %b exp 0", bus.o_cfg_err); else n_pass++;
    bus.i_enable = 1'b1; bus.i_resync = 1'b1;
    tick();
    bus.i_resync = 1'b0;
    n_total++; if (bus.o_edge_count !== 5'd0) $display("FAIL basic_count0 got %0d exp 0", bus.o_edge_count); else n_pass++;
    for (int k = 1; k <= 21; k++) begin
      tick();
      exp_v = (k >= 5) && ((k - 5) % 8 == 0);
      n_total++; if (bus.o_bit_valid !== exp_v) $display("FAIL basic_valid k=%0d got %b exp %b", k, bus.o_bit_valid, exp_v); else n_pass++;
      n_total++; if (bus.o_edge_count !== 5'(k % 8)) $display("FAIL basic_count k=%0d got %0d exp %0d", k, bus.o_edge_count, k % 8); else n_pass++;
      if (exp_v) begin
        n_total++; if (bus.o_sampled_bit !== 1'b0) $display("FAIL basic_sampled k=%0d got %b exp 0", k, bus.o_sampled_bit); else n_pass++;
        n_total++; if (bus.o_noise !== 1'b0) $display("FAIL basic_noise k=%0d got %b exp 0", k, bus.o_noise); else n_pass++;
      end
    end
  endtask

  // Prescale 16, window 6..8; a single 0 at count 7 in the first bit only.
  task automatic test_noise();
    bus.i_prescale = 6'd16; bus.i_rx = 1'b1; bus.i_resync = 1'b1;
    tick();
    bus.i_resync = 1'b0;
    bus.i_rx = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      bus.i_rx = ((k + 2) == 7) ? 1'b0 : 1'b1;
      if (k == 9 || k == 25) begin
        n_total++; if (bus.o_bit_valid !== 1'b1) $display("FAIL noise_valid k=%0d got %b exp 1", k, bus.o_bit_valid); else n_pass++;
        n_total++; if (bus.o_sampled_bit !== 1'b1) $display("FAIL noise_sampled k=%0d got %b exp 1", k, bus.o_sampled_bit); else n_pass++;
        n_total++; if (bus.o_noise !== (k == 9)) $display("FAIL noise_flag k=%0d got %b exp %b", k, bus.o_noise, (k == 9)); else n_pass++;
      end else begin
        n_total++; if (bus.o_bit_valid !== 1'b0) $display("FAIL noise_nostrobe k=%0d got %b exp 0", k, bus.o_bit_valid); else n_pass++;
      end
    end
  endtask

  task automatic test_resync_cancel();
    bus.i_rx = 1'b1; bus.i_resync = 1'b1;
    tick();
    bus.i_resync = 1'b0;
    repeat (5) tick();
    n_total++; if (bus.o_edge_count !== 5'd5) $display("FAIL rsync_count5 got %0d exp 5", bus.o_edge_count); else n_pass++;
    bus.i_resync = 1'b1;
    tick();
    bus.i_resync = 1'b0;
    n_total++; if (bus.o_edge_count !== 5'd0) $display("FAIL rsync_restart got %0d exp 0", bus.o_edge_count); else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_total++; if (bus.o_bit_valid !== 1'b0) $display("FAIL rsync_pre k=%0d got %b exp 0", k, bus.o_bit_valid); else n_pass++;
    end
    // Resync lands on the count-8 decide edge.
    bus.i_resync = 1'b1;
    tick();
    bus.i_resync = 1'b0;
    bus.i_prescale = 6'd8;
    n_total++; if (bus.o_bit_valid !== 1'b0) $display("FAIL rsync_cancel got %b exp 0", bus.o_bit_valid); else n_pass++;
    n_total++; if (bus.o_edge_count !== 5'd0) $display("FAIL rsync_cancel_cnt got %0d exp 0", bus.o_edge_count); else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_total++; if (bus.o_bit_valid !== (k == 9)) $display("FAIL rsync_p16 k=%0d got %b exp %b", k, bus.o_bit_valid, (k == 9)); else n_pass++;
      n_total++; if (bus.o_edge_count !== 5'(k)) $display("FAIL rsync_p16_cnt k=%0d got %0d exp %0d", k, bus.o_edge_count, k); else n_pass++;
    end
    bus.i_resync = 1'b1;
    tick();
    bus.i_resync = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_total++; if (bus.o_bit_valid !== (k == 5)) $display("FAIL rsync_p8 k=%0d got %b exp %b", k, bus.o_bit_valid, (k == 5)); else n_pass++;
      n_total++; if (bus.o_edge_count !== 5'(k % 8)) $display("FAIL rsync_p8_cnt k=%0d got %0d exp %0d", k, bus.o_edge_count, k % 8); else n_pass++;
    end
  endtask

  task automatic test_cfg_err();
    logic exp_v;
    bus.i_enable = 1'b0; bus.i_prescale = 6'd4; bus.i_rx = 1'b1;
    repeat (2) tick();
    n_total++; if (bus.o_cfg_err !== 1'b1) $display("FAIL cfg_p4 got %b exp 1", bus.o_cfg_err); else n_pass++;
    bus.i_enable = 1'b1; bus.i_resync = 1'b1;
    tick();
    bus.i_resync = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_total++; if (bus.o_edge_count !== 5'd0) $display("FAIL cfg_p4_cnt k=%0d got %0d exp 0", k, bus.o_edge_count); else n_pass++;
      n_total++; if (bus.o_bit_valid !== 1'b0) $display("FAIL cfg_p4_valid k=%0d got %b exp 0", k, bus.o_bit_valid); else n_pass++;
    end
    bus.i_enable = 1'b0; bus.i_prescale = 6'd40;
    repeat (2) tick();
    n_total++; if (bus.o_cfg_err !== 1'b1) $display("FAIL cfg_p40 got %b exp 1", bus.o_cfg_err); else n_pass++;
    bus.i_prescale = 6'd6;
    repeat (2) tick();
    n_total++; if (bus.o_cfg_err !== 1'b0) $display("FAIL cfg_p6 got %b exp 0", bus.o_cfg_err); else n_pass++;
    // Window 1..3: bit1 zeros at counts 4,5; bit2 at 0,1; bit3 at 2,3,4,5.
    bus.i_enable = 1'b1; bus.i_resync = 1'b1;
    tick();
    bus.i_resync = 1'b0;
    bus.i_rx = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      bus.i_rx = ((k + 2) inside {[4:7], [14:17]}) ? 1'b0 : 1'b1;
      exp_v = (k == 4 || k == 10 || k == 16);
      n_total++; if (bus.o_bit_valid !== exp_v) $display("FAIL p6_valid k=%0d got %b exp %b", k, bus.o_bit_valid, exp_v); else n_pass++;
      if (exp_v) begin
        n_total++; if (bus.o_sampled_bit !== (k != 16)) $display("FAIL p6_sampled k=%0d got %b exp %b", k, bus.o_sampled_bit, (k != 16)); else n_pass++;
        n_total++; if (bus.o_noise !== (k != 4)) $display("FAIL p6_noise k=%0d got %b exp %b", k, bus.o_noise, (k != 4)); else n_pass++;
      end
    end
  endtask

  // N=5, prescale 32, window 12..16.
  task automatic test_five();
    logic exp_v;
    bus5.i_enable = 1'b0; bus5.i_prescale = 6'd32; bus5.i_rx = 1'b1;
    repeat (3) tick();
    n_total++; if (bus5.o_cfg_err !== 1'b0) $display("FAIL n5_cfg got %b exp 0", bus5.o_cfg_err); else n_pass++;
    bus5.i_enable = 1'b1; bus5.i_resync = 1'b1;
    tick();
    bus5.i_resync = 1'b0;
    for (int k = 1; k <= 49; k++) begin
      tick();
      bus5.i_rx = ((k + 2) inside {13, 15, 16, 46}) ? 1'b0 : 1'b1;
      exp_v = (k == 17 || k == 49);
      n_total++; if (bus5.o_bit_valid !== exp_v) $display("FAIL n5_valid k=%0d got %b exp %b", k, bus5.o_bit_valid, exp_v); else n_pass++;
      if (exp_v) begin
        n_total++; if (bus5.o_sampled_bit !== (k == 49)) $display("FAIL n5_sampled k=%0d got %b exp %b", k, bus5.o_sampled_bit, (k == 49)); else n_pass++;
        n_total++; if (bus5.o_noise !== 1'b1) $display("FAIL n5_noise k=%0d got %b exp 1", k, bus5.o_noise); else n_pass++;
      end
    end
  endtask

  task automatic test_enable_drop();
    bus.i_enable = 1'b0; bus.i_prescale = 6'd8; bus.i_rx = 1'b0;
    repeat (3) tick();
    bus.i_enable = 1'b1; bus.i_resync = 1'b1;
    tick();
    bus.i_resync = 1'b0;
    for (int k = 1; k <= 11; k++) tick();
    n_total++; if (bus.o_edge_count !== 5'd3) $display("FAIL drop_cnt3 got %0d exp 3", bus.o_edge_count); else n_pass++;
    bus.i_enable = 1'b0; bus.i_rx = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_total++; if (bus.o_bit_valid !== 1'b0) $display("FAIL drop_valid k=%0d got %b exp 0", k, bus.o_bit_valid); else n_pass++;
      n_total++; if (bus.o_edge_count !== 5'd0) $display("FAIL drop_cnt k=%0d got %0d exp 0", k, bus.o_edge_count); else n_pass++;
      n_total++; if (bus.o_sampled_bit !== 1'b0) $display("FAIL drop_hold k=%0d got %b exp 0", k, bus.o_sampled_bit); else n_pass++;
    end
    bus.i_enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_total++; if (bus.o_bit_valid !== (k == 5)) $display("FAIL drop_re k=%0d got %b exp %b", k, bus.o_bit_valid, (k == 5)); else n_pass++;
    end
    n_total++; if (bus.o_sampled_bit !== 1'b1) $display("FAIL drop_re_sampled got %b exp 1", bus.o_sampled_bit); else n_pass++;
    n_total++; if (bus.o_noise !== 1'b0) $display("FAIL drop_re_noise got %b exp 0", bus.o_noise); else n_pass++;
  endtask

  task automatic test_async_reset();
    bus.i_enable = 1'b0; bus.i_prescale = 6'd8; bus.i_rx = 1'b0;
    repeat (3) tick();
    bus.i_enable = 1'b1; bus.i_resync = 1'b1;
    tick();
    bus.i_resync = 1'b0;
    for (int k = 1; k <= 11; k++) tick();
    n_total++; if (bus.o_sampled_bit !== 1'b0) $display("FAIL arst_pre_sampled got %b exp 0", bus.o_sampled_bit); else n_pass++;
    n_total++; if (bus.o_edge_count !== 5'd3) $display("FAIL arst_pre_cnt got %0d exp 3", bus.o_edge_count); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.o_bit_valid !== 1'b0) $display("FAIL arst_valid got %b exp 0", bus.o_bit_valid); else n_pass++;
    n_total++; if (bus.o_sampled_bit !== 1'b1) $display("FAIL arst_sampled got %b exp 1", bus.o_sampled_bit); else n_pass++;
    n_total++; if (bus.o_noise !== 1'b0) $display("FAIL arst_noise got %b exp 0", bus.o_noise); else n_pass++;
    n_total++; if (bus.o_edge_count !== 5'd0) $display("FAIL arst_cnt got %0d exp 0", bus.o_edge_count); else n_pass++;
    tick();
    rst_n = 1'b1; bus.i_enable = 1'b0;
    tick();
    bus.i_enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_total++; if (bus.o_bit_valid !== (k == 5)) $display("FAIL arst_strobe k=%0d got %b exp %b", k, bus.o_bit_valid, (k == 5)); else n_pass++;
    end
    n_total++; if (bus.o_sampled_bit !== 1'b0) $display("FAIL arst_post_sampled got %b exp 0", bus.o_sampled_bit); else n_pass++;
    n_total++; if (bus.o_noise !== 1'b0) $display("FAIL arst_post_noise got %b exp 0", bus.o_noise); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_noise();
    test_resync_cancel();
    test_cfg_err();
    test_five();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rx_oversample_voter.md
Name: rx_oversample_voter

Overview:
- Parametrised successor to the UART RX bit-sampling stage.
- Owns its own oversampling edge counter, a configurable odd-count majority vote centred on mid-bit, and an input synchroniser.
- Emits one strobed decision per bit period with a noise flag.
- Sits between the RX line pin and the RX FSM / deserialiser. The FSM controls it with enable and resync (start-edge alignment).

Parameters:
- MAX_PRESCALE, 32: largest supported oversampling ratio; sizes the counters.
- NUM_SAMPLES, 3: votes per bit; odd, range 1..7.
- SYNC_STAGES, 2: flops in the i_rx synchroniser; minimum 2.

Ports:
- i_clk  in  1  oversampling clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_enable  in  1  run bit timing; low = idle.
- i_resync  in  1  one-cycle pulse; restarts the bit period at count 0.
- i_prescale  in  $clog2(MAX_PRESCALE)+1  oversampling ratio (clocks per bit).
- i_rx  in  1  asynchronous serial line.
- o_bit_valid  out  1  one-cycle strobe; the decision is valid.
- o_sampled_bit  out  1  majority-voted bit; held between strobes.
- o_noise  out  1  the samples of the last decision were not unanimous; held.
- o_edge_count  out  $clog2(MAX_PRESCALE)  current position within the bit.
- o_cfg_err  out  1  latched prescale is illegal.

Behaviour:
- Reset values: o_bit_valid=0, o_sampled_bit=1, o_noise=0, o_edge_count=0, o_cfg_err=0. Synchroniser flops reset to 1 (idle line). Vote accumulator 0. prescale_q=MAX_PRESCALE.
- Synchroniser: i_rx passes through SYNC_STAGES flops; all voting uses the last stage (rx_s).
- Prescale latch: prescale_q <= i_prescale only on edges where i_enable=0 or i_resync=1. Changes mid-frame are ignored.
- Legality: prescale_q is legal iff 2*NUM_SAMPLES <= prescale_q <= MAX_PRESCALE.
  - o_cfg_err is registered from prescale_q.
  - While illegal, the block behaves as disabled.
- Window: H=(NUM_SAMPLES-1)/2, MID=prescale_q>>1, window = counts MID-2H .. MID inclusive.
  - Examples: prescale 8 / N 3 gives 2..4; prescale 16 gives 6..8.
  - Legality guarantees MID < prescale_q-1.
- Counter:
  - i_resync=1 (highest priority): count<=0, accumulator<=0.
  - Else if !i_enable or illegal: count<=0, accumulator<=0.
  - Else: count increments, wrapping prescale_q-1 -> 0.
- Accumulate: on each edge where count is inside the window, ones += rx_s and seen += 1. Accumulator widths are $clog2(NUM_SAMPLES+1).
- Decide: on the edge where count==MID, using the totals including this sample:
  - o_sampled_bit <= (ones_total > H).
  - o_noise <= (ones_total != 0 && ones_total != NUM_SAMPLES).
  - o_bit_valid <= 1 for exactly one cycle.
  - Accumulator clears.
- Strobe timing:
  - One strobe per bit period, MID+1 clocks after count 0 is entered.
  - A strobe follows the resync edge by MID+1 clocks.
- Simultaneous events:
  - i_resync on the decide edge: resync wins, no strobe, no output update.
  - i_enable falling mid-window: accumulator discarded, no strobe, o_sampled_bit and o_noise hold.
- Async reset mid-bit: all state returns to reset values immediately; the first strobe after release requires enable plus a full window.
- o_edge_count mirrors the count register.

Decomposition:
- Package rx_sampler_pkg holds:
  - width helper constants CNT_W=$clog2(MAX_PRESCALE) and PS_W=CNT_W+1;
  - VOTE_W;
  - functions win_start(prescale,n) and win_mid(prescale).
- Sub-module rx_sync_ff (parametrised SYNC_STAGES, reset value 1). It is reused later by other RX blocks.
- Voting and counting stay in the top block.

Test Plan:
1. Prescale 8, N=3, i_rx=0 steady, enable, resync pulse -> strobe 5 clocks after resync edge, then every 8 clocks; o_sampled_bit=0, o_noise=0, window counts 2,3,4.
2. Prescale 16, N=3, rx_s=1 except 0 at count 7 -> o_sampled_bit=1, o_noise=1. Next bit clean 1 -> o_noise=0.
3. Prescale 16, resync at count 5, then on the count-8 decide edge -> resync cancels a pending bit (no strobe); next strobe 9 clocks after the latest resync; a mid-frame i_prescale change to 8 is ignored until the next resync.
4. Prescale 4 with N=3 -> o_cfg_err=1, count stays 0, no strobes. Prescale 40 with MAX 32 -> o_cfg_err=1. Prescale 6 -> o_cfg_err=0, window 1..3.
5. N=5, prescale 32, window 12..16, samples 1,0,1,0,0 -> o_sampled_bit=0, o_noise=1. Samples 1,1,0,1,1 -> 1, noise 1.
6. Assert i_rst_n low at count 3 of prescale 8 -> outputs return to 1/0/0/0 asynchronously. After release with enable, the first strobe arrives 5 clocks after count 0.
